// File: rtl/aes_core_arbiter.sv
`default_nettype none
// ============================================================================
// aes_core_arbiter: round-robin sharing of one AES-128 core between the SRAM
// read (decrypt) and write (encrypt) paths.                  Revision: 1.0
// ============================================================================
module aes_core_arbiter #(
  parameter int KEY_WD = 128,
  parameter int BLK_WD = 128,
  parameter int TMO_WD = 8
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic [KEY_WD-1:0] master_key_i,
  input  logic              key_update_i,
  input  logic              alarm_i,
  input  logic              r_req_i,
  input  logic [BLK_WD-1:0] r_blk_i,
  output logic              r_done_o,
  output logic              r_err_o,
  input  logic              w_req_i,
  input  logic [BLK_WD-1:0] w_blk_i,
  output logic              w_done_o,
  output logic              w_err_o,
  output logic [BLK_WD-1:0] result_o,
  output logic              busy_o,
  output logic              aes_init_o,
  output logic              aes_next_o,
  output logic              aes_encdec_o,
  output logic [KEY_WD-1:0] aes_key_o,
  output logic [BLK_WD-1:0] aes_blk_o,
  input  logic              aes_ready_i,
  input  logic              aes_valid_i,
  input  logic [BLK_WD-1:0] aes_result_i
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_KEY_INIT = 3'd1,
    S_KEY_WAIT = 3'd2,
    S_ISSUE    = 3'd3,
    S_RES_WAIT = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;          // 1 = W owns the core
  logic                rr_last_q, rr_last_d;  // 1 = W was served last
  logic                key_stale_q, key_stale_d;
  logic [TMO_WD-1:0]   tmo_q, tmo_d;
  logic                init_q, init_d;
  logic                next_q, next_d;
  logic                encdec_q, encdec_d;
  logic                busy_q, busy_d;
  logic                r_done_q, r_done_d;
  logic                r_err_q, r_err_d;
  logic                w_done_q, w_done_d;
  logic                w_err_q, w_err_d;
  logic [KEY_WD-1:0]   key_q, key_d;
  logic [BLK_WD-1:0]   blk_q, blk_d;
  logic [BLK_WD-1:0]   result_q, result_d;
  logic                tmo_hit;
  logic                settle;
  logic                finish;
  logic                fail;
  logic                waiting;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_last_d   = rr_last_q;
    key_stale_d = key_stale_q;
    encdec_d    = encdec_q;
    key_d       = key_q;
    blk_d       = blk_q;
    result_d    = result_q;
    init_d      = 1'b0;
    next_d      = 1'b0;
    r_done_d    = 1'b0;
    r_err_d     = 1'b0;
    w_done_d    = 1'b0;
    w_err_d     = 1'b0;
    finish      = 1'b0;
    fail        = 1'b0;
    tmo_hit     = (tmo_q == {TMO_WD{1'b1}});
    // The counter is zero only on the first cycle after a state entry.
    settle      = (tmo_q == {TMO_WD{1'b0}});
    waiting     = (state_q == S_KEY_WAIT) || (state_q == S_ISSUE) ||
                  (state_q == S_RES_WAIT);

    case (state_q)
      S_IDLE: begin
        // A done still showing means the requester has not yet dropped req.
        if (!alarm_i && !r_done_q && !w_done_q && (r_req_i || w_req_i)) begin
          if (r_req_i && w_req_i) sel_d = ~rr_last_q;
          else                    sel_d = w_req_i;
          rr_last_d = sel_d;
          encdec_d  = sel_d;
          blk_d     = sel_d ? w_blk_i : r_blk_i;
          state_d   = key_stale_q ? S_KEY_INIT : S_ISSUE;
        end
      end
      S_KEY_INIT: begin
        if (alarm_i) begin
          fail = 1'b1;
        end else begin
          init_d      = 1'b1;
          key_d       = master_key_i;
          key_stale_d = 1'b0;
          state_d     = S_KEY_WAIT;
        end
      end
      S_KEY_WAIT: begin
        if (alarm_i || tmo_hit)          fail = 1'b1;
        else if (!settle && aes_ready_i) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (alarm_i || tmo_hit) begin
          fail = 1'b1;
        end else if (aes_ready_i) begin
          next_d  = 1'b1;
          state_d = S_RES_WAIT;
        end
      end
      S_RES_WAIT: begin
        if (alarm_i || tmo_hit) begin
          fail = 1'b1;
        end else if (!settle && aes_valid_i) begin
          result_d = aes_result_i;
          finish   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      state_d     = S_IDLE;
      key_stale_d = 1'b1;
    end
    if (finish || fail) begin
      r_done_d = ~sel_q;
      w_done_d = sel_q;
      r_err_d  = fail & ~sel_q;
      w_err_d  = fail & sel_q;
    end
    // Overrides the clear in KEY_INIT so a coinciding key change is not lost.
    if (key_update_i || alarm_i) key_stale_d = 1'b1;

    if (state_d != state_q) tmo_d = {TMO_WD{1'b0}};
    else if (waiting)       tmo_d = tmo_q + 1'b1;
    else                    tmo_d = {TMO_WD{1'b0}};

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      rr_last_q   <= 1'b0;
      key_stale_q <= 1'b1;
      tmo_q       <= {TMO_WD{1'b0}};
      init_q      <= 1'b0;
      next_q      <= 1'b0;
      encdec_q    <= 1'b0;
      busy_q      <= 1'b0;
      r_done_q    <= 1'b0;
      r_err_q     <= 1'b0;
      w_done_q    <= 1'b0;
      w_err_q     <= 1'b0;
      key_q       <= {KEY_WD{1'b0}};
      blk_q       <= {BLK_WD{1'b0}};
      result_q    <= {BLK_WD{1'b0}};
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_last_q   <= rr_last_d;
      key_stale_q <= key_stale_d;
      tmo_q       <= tmo_d;
      init_q      <= init_d;
      next_q      <= next_d;
      encdec_q    <= encdec_d;
      busy_q      <= busy_d;
      r_done_q    <= r_done_d;
      r_err_q     <= r_err_d;
      w_done_q    <= w_done_d;
      w_err_q     <= w_err_d;
      key_q       <= key_d;
      blk_q       <= blk_d;
      result_q    <= result_d;
    end
  end

  assign r_done_o     = r_done_q;
  assign r_err_o      = r_err_q;
  assign w_done_o     = w_done_q;
  assign w_err_o      = w_err_q;
  assign result_o     = result_q;
  assign busy_o       = busy_q;
  assign aes_init_o   = init_q;
  assign aes_next_o   = next_q;
  assign aes_encdec_o = encdec_q;
  assign aes_key_o    = key_q;
  assign aes_blk_o    = blk_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_core_arbiter.sv
`default_nettype none
// ============================================================================
// tb_aes_core_arbiter: randomized bench with a behavioural AES core stand-in
// and a transaction-level reference for ordering, key refresh and results.
// ============================================================================
module tb_aes_core_arbiter;

  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         wb_clk_i = 1'b0;
  logic         rst_n;
  logic [127:0] master_key_i;
  logic         key_update_i, alarm_i;
  logic         r_req_i, w_req_i;
  logic [127:0] r_blk_i, w_blk_i;
  logic         r_done_o, r_err_o, w_done_o, w_err_o;
  logic [127:0] result_o;
  logic         busy_o, aes_init_o, aes_next_o, aes_encdec_o;
  logic [127:0] aes_key_o, aes_blk_o;
  logic         aes_ready_i, aes_valid_i;
  logic [127:0] aes_result_i;

  int checks = 0;
  int errors = 0;
  bit exp_stale;
  bit last_w;
  logic [127:0] last_result;
  bit core_hang;

  always #5 wb_clk_i = ~wb_clk_i;

  aes_core_arbiter #(.KEY_WD(128), .BLK_WD(128), .TMO_WD(8)) dut (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n),
    .master_key_i(master_key_i), .key_update_i(key_update_i), .alarm_i(alarm_i),
    .r_req_i(r_req_i), .r_blk_i(r_blk_i), .r_done_o(r_done_o), .r_err_o(r_err_o),
    .w_req_i(w_req_i), .w_blk_i(w_blk_i), .w_done_o(w_done_o), .w_err_o(w_err_o),
    .result_o(result_o), .busy_o(busy_o),
    .aes_init_o(aes_init_o), .aes_next_o(aes_next_o), .aes_encdec_o(aes_encdec_o),
    .aes_key_o(aes_key_o), .aes_blk_o(aes_blk_o),
    .aes_ready_i(aes_ready_i), .aes_valid_i(aes_valid_i), .aes_result_i(aes_result_i)
  );

  // Toy invertible cipher, with the FIPS-197 vector special-cased.
  function automatic logic [127:0] ref_cipher(input logic [127:0] k, input logic [127:0] b,
                                               input logic enc);
    logic [127:0] t;
    if (k == FK && enc && b == FP) return FC;
    if (k == FK && !enc && b == FC) return FP;
    if (enc) return {b[114:0], b[127:115]} ^ k;
    t = b ^ k;
    return {t[12:0], t[127:13]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // AES core stand-in: init expands (latches) the key, next computes with it.
  int           core_mode, core_cnt;
  logic [127:0] core_kexp, core_pend;
  always @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      aes_ready_i <= 1'b1; aes_valid_i <= 1'b0; aes_result_i <= '0;
      core_mode <= 0; core_cnt <= 0; core_kexp <= '0; core_pend <= '0;
    end else if (aes_init_o) begin
      aes_ready_i <= 1'b0; core_mode <= 1; core_cnt <= int'($urandom_range(2, 6));
      core_kexp <= aes_key_o;
    end else if (core_mode == 0) begin
      if (aes_next_o) begin
        aes_ready_i <= 1'b0; aes_valid_i <= 1'b0; core_mode <= 2;
        core_cnt <= int'($urandom_range(1, 10));
        core_pend <= ref_cipher(core_kexp, aes_blk_o, aes_encdec_o);
      end
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
    end else if (core_mode == 1) begin
      aes_ready_i <= 1'b1; core_mode <= 0;
    end else if (!core_hang) begin
      aes_ready_i <= 1'b1; aes_valid_i <= 1'b1; aes_result_i <= core_pend; core_mode <= 0;
    end
  end

  task automatic run_op(input bit want_r, input bit want_w, input logic [127:0] rb,
                        input logic [127:0] wbk);
    bit cur_w, pend_r, pend_w;
    int inits, nexts, cyc;
    logic [127:0] exp_res;
    pend_r = want_r; pend_w = want_w;
    cur_w  = (want_r && want_w) ? !last_w : want_w;
    inits = 0; nexts = 0; cyc = 0;
    r_req_i = want_r; r_blk_i = rb; w_req_i = want_w; w_blk_i = wbk;
    while ((pend_r || pend_w) && cyc < 3000) begin
      @(negedge wb_clk_i); cyc++;
      if (aes_init_o || aes_next_o) check_val("init_next_excl", aes_init_o & aes_next_o, 0);
      if (aes_init_o) begin
        inits++;
        check_val("init_key", aes_key_o, master_key_i);
      end
      if (aes_next_o) begin
        nexts++;
        check_val("next_encdec", aes_encdec_o, cur_w);
        check_val("next_blk", aes_blk_o, cur_w ? wbk : rb);
      end
      if (r_done_o || w_done_o) begin
        check_val("done_overlap", r_done_o & w_done_o, 0);
        check_val("done_who", w_done_o, cur_w);
        check_val("done_err", cur_w ? w_err_o : r_err_o, 0);
        exp_res = ref_cipher(master_key_i, cur_w ? wbk : rb, cur_w);
        check_val("result", result_o, exp_res);
        check_val("init_count", inits, exp_stale);
        check_val("next_count", nexts, 1);
        last_result = exp_res; exp_stale = 0; last_w = cur_w;
        inits = 0; nexts = 0;
        if (cur_w) begin pend_w = 0; w_req_i = 0; end
        else       begin pend_r = 0; r_req_i = 0; end
        cur_w = !cur_w;
      end
    end
    if (pend_r || pend_w) check_val("op_timeout", 1, 0);
    r_req_i = 0; w_req_i = 0;
  endtask

  task automatic new_key(input logic [127:0] k);
    @(negedge wb_clk_i);
    master_key_i = k; key_update_i = 1'b1;
    @(negedge wb_clk_i);
    key_update_i = 1'b0; exp_stale = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    rst_n = 1'b1; exp_stale = 1; last_w = 0; last_result = '0;
  endtask

  task automatic wait_next(input string tag);
    int cyc;
    cyc = 0;
    do begin @(negedge wb_clk_i); cyc++; end while (!aes_next_o && cyc < 200);
    if (!aes_next_o) check_val(tag, 0, 1);
  endtask

  initial begin
    int cyc;
    int pat;
    logic [127:0] b;
    rst_n = 1'b0; master_key_i = FK; key_update_i = 0; alarm_i = 0;
    r_req_i = 0; w_req_i = 0; r_blk_i = '0; w_blk_i = '0; core_hang = 0;
    repeat (2) @(negedge wb_clk_i);
    check_val("rst_ctrl", {r_done_o, r_err_o, w_done_o, w_err_o, busy_o,
                           aes_init_o, aes_next_o, aes_encdec_o}, 0);
    check_val("rst_data", result_o | aes_key_o | aes_blk_o, 0);
    do_reset();

    run_op(0, 1, '0, FP);
    check_val("fips_enc", result_o, FC);
    run_op(1, 0, FC, '0);
    check_val("fips_dec", result_o, FP);

    do_reset();
    run_op(1, 1, rand128(), rand128());

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) new_key(rand128());
      repeat ($urandom_range(0, 2)) @(negedge wb_clk_i);
      pat = int'($urandom_range(0, 2));
      run_op(pat != 1, pat != 0, rand128(), rand128());
    end

    // Alarm while the core is computing.
    core_hang = 1; w_req_i = 1; w_blk_i = rand128();
    wait_next("alarm_no_next");
    repeat (3) @(negedge wb_clk_i);
    check_val("alarm_busy_before", busy_o, 1);
    alarm_i = 1;
    @(negedge wb_clk_i);
    check_val("alarm_done", {w_done_o, w_err_o, r_done_o}, 3'b110);
    check_val("alarm_busy_after", busy_o, 0);
    check_val("alarm_result_held", result_o, last_result);
    alarm_i = 0; w_req_i = 0; exp_stale = 1; core_hang = 0;
    @(negedge wb_clk_i);
    run_op(0, 1, rand128(), rand128());

    // Core that never returns valid.
    core_hang = 1; r_req_i = 1; r_blk_i = rand128();
    wait_next("tmo_no_next");
    cyc = 0;
    do begin @(negedge wb_clk_i); cyc++; end while (!r_done_o && cyc < 400);
    check_val("tmo_done_err", {r_done_o, r_err_o, w_done_o}, 3'b110);
    check_val("tmo_window", (cyc >= 250 && cyc <= 260), 1);
    check_val("tmo_result_held", result_o, last_result);
    r_req_i = 0; exp_stale = 1;
    @(negedge wb_clk_i);

    // Asynchronous reset in the middle of an operation.
    w_req_i = 1; w_blk_i = rand128();
    wait_next("rst_no_next");
    @(negedge wb_clk_i);
    check_val("midop_busy", busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("midop_rst_ctrl", {r_done_o, r_err_o, w_done_o, w_err_o, busy_o,
                                 aes_init_o, aes_next_o, aes_encdec_o}, 0);
    check_val("midop_rst_data", result_o | aes_key_o | aes_blk_o, 0);
    w_req_i = 0;
    repeat (2) @(negedge wb_clk_i);
    rst_n = 1'b1;
    repeat (2) @(negedge wb_clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
